regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle mul/div unit. WB traffic has priority and is never delayed. Mul/div results wait in a 2-entry FIFO and drain into free write slots. If a result waits too long, a one-cycle freeze request to the pipeline opens a slot for it. The block sits between WB, the mul/div unit and the register file write port, and feeds a pending-register mask to the hazard unit.

## Interface
- WORD_LEN, 32, data width
- ADDR_LEN, 5, register address width (2**ADDR_LEN registers)
- STARVE_LIMIT, 4, consecutive blocked cycles before a freeze is requested (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_en  in  1  WB write request this cycle
- wb_addr  in  ADDR_LEN  WB destination
- wb_data  in  WORD_LEN  WB value
- md_valid  in  1  mul/div result valid
- md_ready  out  1  FIFO can accept
- md_addr  in  ADDR_LEN  mul/div destination
- md_data  in  WORD_LEN  mul/div value
- rf_we  out  1  register file write enable
- rf_addr  out  ADDR_LEN  register file write address
- rf_data  out  WORD_LEN  register file write data
- freeze_req  out  1  registered; pipeline must drive wb_en=0 in this cycle
- pend_mask  out  2**ADDR_LEN  bit i set when any FIFO entry targets register i (bit 0 always 0)
- err_collision  out  1  sticky; set by wb_en=1 while freeze_req=1

## Operation
- Reset values: FIFO empty, starvation counter 0, state IDLE, freeze_req 0, err_collision 0, pend_mask 0, rf_we 0, md_ready 0 while rst is high.
- Push: md_valid & md_ready writes {md_addr, md_data} to the FIFO tail. md_ready = (count<2) & ~rst, derived from the registered count.
- WB write: wb_en & (wb_addr≠0) drives rf_we=1 with rf_addr/rf_data taken from WB.
- Slot free: the slot is free when the WB write condition is false.
  - If the slot is free and the FIFO is non-empty, pop the head and drive it to the write port.
  - If the head address is 0, pop it with rf_we=0.
- Push and pop in the same cycle are both legal; the count is unchanged.
- No bypass: an accepted entry is written no earlier than the next cycle.
- Collision: wb_en=1 with freeze_req=1 means WB still wins, the head is not popped, and err_collision sets and holds until rst.
- Ordering between WB and mul/div writes to the same register is the hazard unit's responsibility, using pend_mask.
- FSM:
  - IDLE: FIFO empty. Move to WAIT when an entry is present after the edge.
  - WAIT: non-empty. The counter increments each cycle the FIFO is non-empty without a pop, and clears on any pop. The counter reaching STARVE_LIMIT moves the FSM to FREEZE. The FIFO becoming empty moves it to IDLE.
  - FREEZE: freeze_req=1 for exactly one cycle; the head pops in that cycle and the counter clears. Then go to WAIT if the FIFO is still non-empty, else IDLE.
- Arithmetic: the counter is wide enough for STARVE_LIMIT and saturates there. The FIFO pointers are 1 bit and wrap modulo 2.

## Timing
- rf_* outputs are combinational from wb_* and the FIFO head: zero-cycle latency for WB.
- Minimum mul/div latency is 1 cycle from accept to rf_we.
- Maximum mul/div latency with the FIFO entry at head is STARVE_LIMIT+1 cycles after it reaches head.
- freeze_req, md_ready and pend_mask change only after clock edges or rst.
- pend_mask reflects FIFO contents after the edge; a popped entry clears its bit the following cycle unless another entry holds the same address.
- rst mid-operation: discards FIFO contents immediately; no rf_we is issued while rst is high.

## Structure
- Shared package: WORD_LEN/ADDR_LEN defaults and the arbiter state encoding (IDLE, WAIT, FREEZE).
- One sub-module, `wr_fifo2`: a 2-entry FIFO holding {addr, data}, with count, head and per-entry outputs for pend_mask.

## Test plan
- Reset, then md push addr 5 / 0xAAAA_0001 with wb_en=0 -> rf_we=1, rf_addr=5, rf_data=0xAAAA_0001 the next cycle; pend_mask bit 5 clear afterwards.
- Two pushes (addr 3, addr 4) while wb_en=1 continuously -> md_ready=0 after the second push; freeze_req=1 on the 5th blocked cycle; addr 3 written in that cycle; addr 4 written after a further 4 blocked cycles plus a freeze.
- Push to addr 0 with the slot free -> entry popped, rf_we=0, FIFO empty next cycle.
- WB write to addr 0 with FIFO head addr 7 -> the head writes in the same cycle (rf_addr=7).
- wb_en=1 during freeze_req -> WB write occurs, err_collision=1 and stays set.
- rst asserted with 2 FIFO entries -> md_ready=0, pend_mask=0, freeze_req=0 immediately; after release, no stale writes.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register file write arbiter.
// - WORD_LEN_DEF / ADDR_LEN_DEF : default data and register address widths
// - arb_state_e                 : arbiter FSM state encoding
package regfile_write_arbiter_pkg;

    localparam int unsigned WORD_LEN_DEF = 32;
    localparam int unsigned ADDR_LEN_DEF = 5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StFreeze = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo2.sv
// wr_fifo2: 2-entry FIFO of {addr, data} for mul/div results.
// Ports:
//   clk, rst                 clock, async active-high reset (empties the FIFO)
//   push_i / push_addr_i / push_data_i   write to tail (ignored when full)
//   pop_i                    drop head (ignored when empty)
//   count_o                  number of stored entries (0..2)
//   head_addr_o/head_data_o  oldest entry
//   ent_vld_o / ent_addr_o   per-slot occupancy and address (for pending mask)
module wr_fifo2
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LEN = WORD_LEN_DEF,
    parameter int unsigned ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [ADDR_LEN-1:0]      push_addr_i,
    input  logic [WORD_LEN-1:0]      push_data_i,
    input  logic                     pop_i,
    output logic [1:0]               count_o,
    output logic [ADDR_LEN-1:0]      head_addr_o,
    output logic [WORD_LEN-1:0]      head_data_o,
    output logic [1:0]               ent_vld_o,
    output logic [1:0][ADDR_LEN-1:0] ent_addr_o
);

    logic [ADDR_LEN-1:0] addr_q [2];
    logic [WORD_LEN-1:0] data_q [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic                push_ok, pop_ok;

    always_comb begin
        push_ok  = push_i & (count_q != 2'd2);
        pop_ok   = pop_i & (count_q != 2'd0);
        wr_ptr_d = push_ok ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_ok ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + 2'(push_ok) - 2'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        count_o       = count_q;
        head_addr_o   = addr_q[rd_ptr_q];
        head_data_o   = data_q[rd_ptr_q];
        ent_addr_o[0] = addr_q[0];
        ent_addr_o[1] = addr_q[1];
        ent_vld_o     = 2'b00;
        if (count_q == 2'd2) begin
            ent_vld_o = 2'b11;
        end else if (count_q == 2'd1) begin
            ent_vld_o[rd_ptr_q] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between the WB
// stage (always wins) and a 2-deep queue of mul/div results. A result that is
// blocked STARVE_LIMIT cycles in a row triggers a one-cycle freeze request
// that opens a write slot for it.
// Ports:
//   clk, rst                       clock, async active-high reset
//   wb_en_i/wb_addr_i/wb_data_i    WB write request
//   md_valid_i/md_addr_i/md_data_i mul/div result, accepted when md_ready_o
//   md_ready_o                     FIFO has space (registered count, low in reset)
//   rf_we_o/rf_addr_o/rf_data_o    register file write port (combinational)
//   freeze_req_o                   registered; pipeline must hold wb_en_i low
//   pend_mask_o                    registers targeted by queued results
//   err_collision_o                sticky: WB wrote during a freeze cycle
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LEN     = WORD_LEN_DEF,
    parameter int unsigned ADDR_LEN     = ADDR_LEN_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en_i,
    input  logic [ADDR_LEN-1:0]      wb_addr_i,
    input  logic [WORD_LEN-1:0]      wb_data_i,
    input  logic                     md_valid_i,
    output logic                     md_ready_o,
    input  logic [ADDR_LEN-1:0]      md_addr_i,
    input  logic [WORD_LEN-1:0]      md_data_i,
    output logic                     rf_we_o,
    output logic [ADDR_LEN-1:0]      rf_addr_o,
    output logic [WORD_LEN-1:0]      rf_data_o,
    output logic                     freeze_req_o,
    output logic [2**ADDR_LEN-1:0]   pend_mask_o,
    output logic                     err_collision_o
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    arb_state_e              state_q, state_d;
    logic [CntW-1:0]         starve_q, starve_d;
    logic                    err_q, err_d;

    logic [1:0]              count;
    logic [1:0]              count_nxt;
    logic [ADDR_LEN-1:0]     head_addr;
    logic [WORD_LEN-1:0]     head_data;
    logic [1:0]              ent_vld;
    logic [1:0][ADDR_LEN-1:0] ent_addr;

    logic                    wb_write;
    logic                    in_freeze;
    logic                    collision;
    logic                    push;
    logic                    pop;

    // Slot arbitration. A WB request during a freeze still wins and also
    // holds the head in place, even if it targets register 0.
    always_comb begin
        wb_write   = wb_en_i & (wb_addr_i != '0);
        in_freeze  = (state_q == StFreeze);
        collision  = wb_en_i & in_freeze;
        md_ready_o = (count != 2'd2) & ~rst;
        push       = md_valid_i & md_ready_o;
        pop        = (count != 2'd0) & ~wb_write & ~collision & ~rst;
        count_nxt  = count + 2'(push) - 2'(pop);
        err_d      = err_q | collision;
    end

    wr_fifo2 #(
        .WORD_LEN (WORD_LEN),
        .ADDR_LEN (ADDR_LEN)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (md_addr_i),
        .push_data_i (md_data_i),
        .pop_i       (pop),
        .count_o     (count),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .ent_vld_o   (ent_vld),
        .ent_addr_o  (ent_addr)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // FSM next state. State follows the FIFO occupancy seen after the edge.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle: begin
                starve_d = '0;
                if (count_nxt != 2'd0) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (pop) begin
                    starve_d = '0;
                end else if (starve_q != Limit) begin
                    starve_d = starve_q + CntW'(1);
                end
                if (count_nxt == 2'd0) begin
                    state_d = StIdle;
                end else if (starve_d == Limit) begin
                    state_d = StFreeze;
                end
            end
            StFreeze: begin
                starve_d = '0;
                state_d  = (count_nxt != 2'd0) ? StWait : StIdle;
            end
            default: begin
                starve_d = '0;
                state_d  = StIdle;
            end
        endcase
    end

    // FSM / datapath outputs
    always_comb begin
        freeze_req_o    = in_freeze;
        err_collision_o = err_q;
        rf_we_o         = 1'b0;
        rf_addr_o       = '0;
        rf_data_o       = '0;
        if (!rst) begin
            if (wb_write) begin
                rf_we_o   = 1'b1;
                rf_addr_o = wb_addr_i;
                rf_data_o = wb_data_i;
            end else if (pop) begin
                // Head targeting register 0 is dropped without a write.
                rf_we_o   = (head_addr != '0);
                rf_addr_o = head_addr;
                rf_data_o = head_data;
            end
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int j = 0; j < 2; j++) begin
            if (ent_vld[j]) begin
                pend_mask_o[ent_addr[j]] = 1'b1;
            end
        end
        pend_mask_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int unsigned LIMIT = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        freeze_req;
    logic [31:0] pend_mask;
    logic        err_collision;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model state
    ent_t        m_q[$];
    int          m_run;
    logic        m_freeze;
    logic        m_err;

    regfile_write_arbiter #(
        .WORD_LEN     (32),
        .ADDR_LEN     (5),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_en_i         (wb_en),
        .wb_addr_i       (wb_addr),
        .wb_data_i       (wb_data),
        .md_valid_i      (md_valid),
        .md_ready_o      (md_ready),
        .md_addr_i       (md_addr),
        .md_data_i       (md_data),
        .rf_we_o         (rf_we),
        .rf_addr_o       (rf_addr),
        .rf_data_o       (rf_data),
        .freeze_req_o    (freeze_req),
        .pend_mask_o     (pend_mask),
        .err_collision_o (err_collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_run    = 0;
        m_freeze = 1'b0;
        m_err    = 1'b0;
    endtask

    // One clock edge of the model: WB owns the port, a queued result goes out
    // on any slot WB leaves alone (except a freeze cycle WB illegally used).
    task automatic model_step();
        logic wbw, col, pop, had, was_frz;
        wbw     = wb_en && (wb_addr != 5'd0);
        col     = wb_en && m_freeze;
        had     = (m_q.size() != 0);
        pop     = had && !wbw && !col;
        was_frz = m_freeze;
        if (col) m_err = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (md_valid && (m_q.size() + (pop ? 1 : 0)) < 2) m_q.push_back('{md_addr, md_data});
        if (was_frz || pop || !had) m_run = 0;
        else if (m_run < LIMIT) m_run++;
        m_freeze = !was_frz && (m_run >= LIMIT) && (m_q.size() != 0);
    endtask

    task automatic check_model();
        logic        wbw, col, pop, e_we, e_rdy;
        logic [31:0] e_mask;
        e_mask = '0;
        foreach (m_q[i]) if (m_q[i].addr != 5'd0) e_mask[m_q[i].addr] = 1'b1;
        wbw   = wb_en && (wb_addr != 5'd0);
        col   = wb_en && m_freeze;
        pop   = (m_q.size() != 0) && !wbw && !col;
        e_rdy = !rst && (m_q.size() < 2);
        e_we  = !rst && (wbw || (pop && m_q[0].addr != 5'd0));
        chk("m_rf_we", 64'(rf_we), 64'(e_we));
        if (e_we && wbw) begin
            chk("m_rf_addr_wb", 64'(rf_addr), 64'(wb_addr));
            chk("m_rf_data_wb", 64'(rf_data), 64'(wb_data));
        end else if (e_we) begin
            chk("m_rf_addr_md", 64'(rf_addr), 64'(m_q[0].addr));
            chk("m_rf_data_md", 64'(rf_data), 64'(m_q[0].data));
        end
        chk("m_md_ready", 64'(md_ready), 64'(e_rdy));
        chk("m_pend_mask", 64'(pend_mask), 64'(e_mask));
        chk("m_freeze_req", 64'(freeze_req), 64'(m_freeze));
        chk("m_err_collision", 64'(err_collision), 64'(m_err));
    endtask

    // Compare process: DUT against model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check_model();
        end
    end

    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                         input logic [31:0] md);
        rst = r; wb_en = we; wb_addr = wa; wb_data = wd;
        md_valid = mv; md_addr = ma; md_data = md;
        if (r) model_clear();
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
        drive(1'b0, we, wa, wd, mv, ma, md);
        adv();
    endtask

    initial begin
        model_clear();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("reset_md_ready", 64'(md_ready), 64'd0);
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_pend", 64'(pend_mask), 64'd0);
        adv();
        adv();

        // Single result, free slot: written the following cycle.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAAAA_0001);
        @(negedge clk);
        chk("t1_no_bypass", 64'(rf_we), 64'd0);
        chk("t1_ready_empty", 64'(md_ready), 64'd1);
        adv();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t1_pend_bit5", 64'(pend_mask), 64'h20);
        chk("t1_we", 64'(rf_we), 64'd1);
        chk("t1_addr", 64'(rf_addr), 64'd5);
        chk("t1_data", 64'(rf_data), 64'hAAAA_0001);
        adv();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t1_pend_clear", 64'(pend_mask), 64'd0);
        adv();

        // Two results starved by continuous WB traffic.
        cyc(1'b1, 5'd10, 32'h1000_0000, 1'b1, 5'd3, 32'h3333_3333);
        for (int k = 1; k <= 11; k++) begin
            drive(1'b0, !m_freeze, 5'd10, 32'h1000_0000 + k, k == 1, 5'd4, 32'h4444_4444);
            @(negedge clk);
            chk("t2_freeze", 64'(freeze_req), 64'((k == 5) || (k == 10)));
            if (k == 2) chk("t2_full", 64'(md_ready), 64'd0);
            if (k == 5) begin
                chk("t2_w3_we", 64'(rf_we), 64'd1);
                chk("t2_w3_addr", 64'(rf_addr), 64'd3);
            end
            if (k == 10) begin
                chk("t2_w4_addr", 64'(rf_addr), 64'd4);
                chk("t2_w4_data", 64'(rf_data), 64'h4444_4444);
            end
            if (k == 11) chk("t2_empty_pend", 64'(pend_mask), 64'd0);
            adv();
        end

        // Result for register 0 is dropped without a write.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_0000);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t3_r0_no_we", 64'(rf_we), 64'd0);
        adv();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // WB to register 0 leaves the slot free for the head.
        cyc(1'b1, 5'd9, 32'h9999_9999, 1'b1, 5'd7, 32'h0000_0077);
        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t4_we", 64'(rf_we), 64'd1);
        chk("t4_addr", 64'(rf_addr), 64'd7);
        chk("t4_data", 64'(rf_data), 64'h77);
        adv();

        // WB ignores the freeze: WB wins, error latches.
        cyc(1'b1, 5'd9, 32'h9000_0000, 1'b1, 5'd12, 32'hCCCC_0012);
        for (int k = 1; k <= 4; k++) cyc(1'b1, 5'd9, 32'h9000_0000 + k, 1'b0, 5'd0, 32'd0);
        drive(1'b0, 1'b1, 5'd9, 32'h9000_0005, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t5_freeze", 64'(freeze_req), 64'd1);
        chk("t5_wb_addr", 64'(rf_addr), 64'd9);
        chk("t5_err_not_yet", 64'(err_collision), 64'd0);
        adv();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            @(negedge clk);
            chk("t5_err_sticky", 64'(err_collision), 64'd1);
            if (k == 0) chk("t5_head_after", 64'(rf_addr), 64'd12);
            adv();
        end

        // Reset with two queued results.
        cyc(1'b1, 5'd9, 32'd1, 1'b1, 5'd1, 32'h1111_1111);
        cyc(1'b1, 5'd9, 32'd2, 1'b1, 5'd2, 32'h2222_2222);
        drive(1'b0, 1'b1, 5'd9, 32'd3, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t6_full", 64'(md_ready), 64'd0);
        chk("t6_pend", 64'(pend_mask), 64'h6);
        adv();
        drive(1'b1, 1'b1, 5'd9, 32'd4, 1'b1, 5'd8, 32'd8);
        @(negedge clk);
        chk("t6_rst_ready", 64'(md_ready), 64'd0);
        chk("t6_rst_pend", 64'(pend_mask), 64'd0);
        chk("t6_rst_freeze", 64'(freeze_req), 64'd0);
        chk("t6_rst_we", 64'(rf_we), 64'd0);
        chk("t6_rst_err", 64'(err_collision), 64'd0);
        adv();
        adv();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            @(negedge clk);
            chk("t6_no_stale", 64'(rf_we), 64'd0);
            adv();
        end

        // Mixed traffic, checked by the model only.
        for (int k = 0; k < 80; k++) begin
            logic we;
            we = !m_freeze && ($urandom_range(0, 3) != 0);
            cyc(we, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 31)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
